// File: rtl/buzz_arbiter.sv
// buzz_arbiter: fixed-priority sharing of one piezo buzzer with gated ON/OFF beep patterns
// Ports: clk, rst (sync, active-high); req[2:0] request levels, bit 2 highest priority;
//    req_count[11:0] 4-bit beep count per requester; ack[2:0]/done[2:0] one-hot pulses;
//    aborted flags a pre-empted done; grant[2:0] one-hot owner; busy; buzz_en buzzer gate.
// Optional: define BUZZ_PREEMPT_EN to let a higher-priority request cut a running sequence short.
module buzz_arbiter #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [11:0] req_count,
   output logic [2:0]  ack,
   output logic [2:0]  done,
   output logic        aborted,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        buzz_en
);
   typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
   state_t state_q, state_d;
   logic [1:0] owner_q, owner_d, win;
   logic [3:0] remaining_q, remaining_d;
   logic [26:0] div_q, div_d;
   logic abort_q, abort_d, tick, preempt;
   logic [2:0] ack_q, ack_d, done_q, done_d, grant_q, grant_d;
   logic aborted_q, aborted_d, busy_q, busy_d, buzz_q, buzz_d;
   assign win  = req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
   assign tick = div_q == 27'(TICK_DIV - 1);
`ifdef BUZZ_PREEMPT_EN
   assign preempt = owner_q == 2'd0 ? |req[2:1] : owner_q == 2'd1 ? req[2] : 1'b0;
`else
   assign preempt = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      remaining_d = remaining_q;
      div_d       = div_q + 27'd1;
      abort_d     = abort_q;
      ack_d       = '0;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (|req) begin
               owner_d     = win;
               remaining_d = req_count[{win, 2'b00} +: 4];
               ack_d       = 3'b001 << win;
               state_d     = remaining_d != 4'd0 ? ON : DONE;
            end
         end
         ON: begin
            if (preempt) begin
               state_d = DONE;
               abort_d = 1'b1;
            end else if (tick) begin
               div_d       = '0;
               remaining_d = remaining_q - {3'b000, |remaining_q};
               state_d     = OFF;
            end
         end
         OFF: begin
            if (preempt) begin
               state_d = DONE;
               abort_d = 1'b1;
            end else if (tick) begin
               div_d   = '0;
               state_d = remaining_q != 4'd0 ? ON : DONE;
            end
         end
         default: begin
            div_d   = '0;
            abort_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      // outputs are registered copies of what the next state will present
      done_d    = state_d == DONE ? 3'b001 << owner_d : 3'b000;
      aborted_d = state_d == DONE && abort_d;
      grant_d   = state_d != IDLE ? 3'b001 << owner_d : 3'b000;
      busy_d    = state_d != IDLE;
      buzz_d    = state_d == ON;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         remaining_q <= '0;
         div_q       <= '0;
         abort_q     <= 1'b0;
         ack_q       <= '0;
         done_q      <= '0;
         aborted_q   <= 1'b0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         buzz_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         remaining_q <= remaining_d;
         div_q       <= div_d;
         abort_q     <= abort_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         buzz_q      <= buzz_d;
      end
   end
   assign ack     = ack_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign buzz_en = buzz_q;
endmodule

// File: tb/tb_buzz_arbiter.sv
// tb_buzz_arbiter: directed checks of buzz_arbiter with TICK_DIV = 4
module tb_buzz_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [11:0] req_count = '0;
   logic [2:0]  ack, done, grant;
   logic        aborted, busy, buzz_en;
   int n_checks = 0;
   int n_fail = 0;
   buzz_arbiter #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_count(req_count),
      .ack(ack), .done(done), .aborted(aborted), .grant(grant),
      .busy(busy), .buzz_en(buzz_en)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] all_outs();
      return {20'd0, ack, done, aborted, grant, busy, buzz_en};
   endfunction
`ifdef BUZZ_PREEMPT_EN
   localparam int P_DONE = 7, P_ACK = 9, P_ABT = 1;
`else
   localparam int P_DONE = 41, P_ACK = 43, P_ABT = 0;
`endif
   initial begin
      logic [31:0] pat;
      step();
      step();
      check("reset outputs", all_outs(), 0);
      rst = 1'b0;
      step();
      check("idle outputs", all_outs(), 0);
      // count 2 on req0
      pat = 32'h0000_1E1E;
      req_count = 12'h002;
      req = 3'b001;
      for (int c = 1; c <= 18; c++) begin
         step();
         if (c == 1) req = 3'b000;
         check($sformatf("s1 buzz c%0d", c), {31'd0, buzz_en}, {31'd0, pat[c]});
         check($sformatf("s1 ack c%0d", c), {29'd0, ack}, c == 1 ? 32'd1 : 32'd0);
         check($sformatf("s1 done c%0d", c), {29'd0, done}, c == 17 ? 32'd1 : 32'd0);
         check($sformatf("s1 busy c%0d", c), {31'd0, busy}, c <= 17 ? 32'd1 : 32'd0);
         check($sformatf("s1 grant c%0d", c), {29'd0, grant}, c <= 17 ? 32'd1 : 32'd0);
      end
      // zero count on req1
      req_count = 12'h000;
      req = 3'b010;
      step();
      req = 3'b000;
      check("s2 c1 outs", all_outs(), {20'd0, 3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0});
      step();
      check("s2 c2 outs", all_outs(), 0);
      step();
      // req0 and req2 together, count 1 each
      req_count = 12'h101;
      req = 3'b101;
      for (int c = 1; c <= 21; c++) begin
         step();
         if (c == 1) req = 3'b001;
         if (c == 11) req = 3'b000;
         check($sformatf("s3 ack c%0d", c), {29'd0, ack},
               c == 1 ? 32'd4 : c == 11 ? 32'd1 : 32'd0);
         check($sformatf("s3 done c%0d", c), {29'd0, done},
               c == 9 ? 32'd4 : c == 19 ? 32'd1 : 32'd0);
         check($sformatf("s3 busy c%0d", c), {31'd0, busy},
               (c <= 9 || (c >= 11 && c <= 19)) ? 32'd1 : 32'd0);
      end
      // reset in the middle of a count-3 sequence
      req_count = 12'h003;
      req = 3'b001;
      for (int c = 1; c <= 6; c++) begin
         step();
         req = 3'b000;
      end
      check("s4 c6 busy", {31'd0, busy}, 1);
      check("s4 c6 buzz", {31'd0, buzz_en}, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("s4 c7 outs", all_outs(), 0);
      step();
      check("s4 c8 outs", all_outs(), 0);
      req_count = 12'h001;
      req = 3'b001;
      for (int c = 1; c <= 10; c++) begin
         step();
         req = 3'b000;
         check($sformatf("s4b ack c%0d", c), {29'd0, ack}, c == 1 ? 32'd1 : 32'd0);
         check($sformatf("s4b done c%0d", c), {29'd0, done}, c == 9 ? 32'd1 : 32'd0);
         check($sformatf("s4b buzz c%0d", c), {31'd0, buzz_en}, c <= 4 ? 32'd1 : 32'd0);
      end
      // req0 count 5 running, req2 raised at cycle 6
      req_count = 12'h105;
      req = 3'b001;
      for (int c = 1; c <= P_ACK + 1; c++) begin
         step();
         if (c == 1) req = 3'b000;
         if (c == 6) req = 3'b100;
         if (c == P_ACK) req = 3'b000;
         check($sformatf("s5 done c%0d", c), {29'd0, done}, c == P_DONE ? 32'd1 : 32'd0);
         check($sformatf("s5 aborted c%0d", c), {31'd0, aborted}, c == P_DONE ? P_ABT : 32'd0);
         check($sformatf("s5 ack c%0d", c), {29'd0, ack},
               c == 1 ? 32'd1 : c == P_ACK ? 32'd4 : 32'd0);
         if (c == P_DONE)
            check("s5 buzz at done", {31'd0, buzz_en}, 0);
         if (c == P_ACK)
            check("s5 grant at ack", {29'd0, grant}, 4);
      end
      for (int c = 0; c < 12; c++) step();
      check("final idle", all_outs(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/buzz_arbiter.md
# buzz_arbiter

Shares the single piezo buzzer between three requesters: key-click (0), hourly chime (1) and alarm (2), by fixed priority. It latches the winner's beep count and generates a gated beep pattern of N half-second ON / half-second OFF pairs on `buzz_en`. It sits between the clock/alarm control logic and the buzzer tone driver, which produces the audio square wave whenever `buzz_en` is high.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per ON phase and per OFF phase (0.5 s at 100 MHz). Legal range is 2 to 2^27-1.

Ports:
- `clk`  in  1  system clock, all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  3  request levels; bit 2 has the highest priority
- `req_count`  in  12  beep counts, packed 4 bits per requester: `[3:0]` for req0, `[7:4]` for req1, `[11:8]` for req2
- `ack`  out  3  one-cycle one-hot pulse: the request is latched
- `done`  out  3  one-cycle one-hot pulse: the owner's sequence has ended
- `aborted`  out  1  high together with `done` when the sequence was pre-empted
- `grant`  out  3  one-hot current owner, 0 when idle
- `busy`  out  1  high in every state except IDLE
- `buzz_en`  out  1  buzzer gate

## Operation
- States: IDLE, ON, OFF, DONE. Internal registers:
  - `owner` (2 b)
  - `remaining` (4 b)
  - `div` (27 b)
  - `abort_flag`
- IDLE: if any `req` bit is high, the highest-priority one wins:
  - `owner` and `remaining` are loaded from `req_count[owner]`, `div` is cleared, and `ack[owner]` pulses.
  - If the count is nonzero, go to ON.
  - If the count is 0, go to DONE; the `ack` and `done` pulses then fall on the same cycle and `buzz_en` never rises.
- ON: `buzz_en` = 1. When `div` reaches `TICK_DIV-1`, clear `div`, decrement `remaining`, and go to OFF.
- OFF: `buzz_en` = 0. When `div` reaches `TICK_DIV-1`, clear `div`. Go to ON if `remaining` != 0, otherwise go to DONE.
- DONE: `done[owner]` pulses and `aborted` = `abort_flag`. Clear `grant` and `abort_flag`, then go to IDLE.
- Requests are one-shot. Deasserting `req` after `ack` does not stop the sequence. A `req` held high is granted again when it is next evaluated in IDLE.
- Lower-priority requests that arrive while `busy` are not lost while they stay asserted. They are served in priority order, one per IDLE cycle.
- `grant` is valid from the `ack` cycle through the DONE cycle inclusive.

## Timing
- All outputs are registered. Reset value of every output is 0; state returns to IDLE and all internal registers clear.
- `rst` mid-sequence: the next cycle, `buzz_en` = 0 and `grant` = 0, with no `done` pulse.
- Latency: a `req` high in IDLE at cycle t gives `ack`, `grant` and `buzz_en` = 1 at cycle t+1.
- Each ON and OFF phase lasts exactly `TICK_DIV` cycles.
- For count N, `done` falls at cycle t+1+2N·`TICK_DIV`. IDLE follows one cycle later, and the earliest next `ack` is one cycle after that.
- `div` restarts at each grant, so beep edges are aligned to the grant and not to a free-running timer.
- A count of 15 is the maximum; no wrap occurs because `remaining` is only decremented while nonzero.

## Configuration
- `BUZZ_PREEMPT_EN` defined: in ON or OFF, a `req` bit with higher priority than `owner` causes a transition to DONE on the next cycle:
  - `abort_flag` is set, so `aborted` = 1 with `done[old owner]`.
  - `buzz_en` drops to 0 in that DONE cycle.
  - The IDLE cycle that follows grants the new requester.
- `BUZZ_PREEMPT_EN` undefined: no pre-emption. `aborted` is tied to 0, and higher-priority requests wait for DONE.

## Test plan
All scenarios use `TICK_DIV` = 4.
- req0 with count 2, pulsed at cycle 0:
  - `ack[0]` at cycle 1.
  - `buzz_en` high for cycles 1-4 and 9-12, low for cycles 5-8 and 13-16.
  - `done[0]` at cycle 17; `busy` is low at cycle 18.
- req1 with count 0: `ack[1]` and `done[1]` both at cycle 1, `buzz_en` stays 0, and `busy` is high only at cycle 1.
- req0 and req2 raised together at cycle 0 and held, with counts 1 and 1:
  - `ack[2]` at cycle 1 and `done[2]` at cycle 9.
  - `ack[0]` at cycle 11 and `done[0]` at cycle 19.
- `rst` raised at cycle 6 of a count-3 sequence: at cycle 7, all outputs are 0 and there is no `done`. A new req0 is granted normally afterwards.
- With `BUZZ_PREEMPT_EN`, req0 is running with count 5 and req2 is raised at cycle 6:
  - At cycle 7: `done[0]` = 1, `aborted` = 1, `buzz_en` = 0.
  - At cycle 9: `ack[2]`.
- Without `BUZZ_PREEMPT_EN`, the same stimulus gives `done[0]` at cycle 41, `aborted` = 0, and `ack[2]` at cycle 43.
